kst_clock_counter: RTL and testbench
====================================

# kst_clock_counter

- Primary time-keeping stage of the world-clock datapath: maintains Korea Standard Time as hours, minutes and seconds from the system clock.
- `hour_kst` feeds the downstream world-time conversion stage directly, always in range 0–23.
- Supports a validated full-time load and per-field manual adjustment while stopped.
- Emits per-second and per-day strobes for display and alarm logic.

## Interface

Parameters:
- `CLK_HZ`, default 50_000_000: `clk` cycles per second; prescaler terminal count is `CLK_HZ-1`. Minimum 2.

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `run`  in  1  level; 1 = time advances, 0 = stopped (prescaler frozen)
- `set_valid`  in  1  one-cycle load request for `set_hour`/`set_min`/`set_sec`
- `set_hour`  in  5  load value, legal 0–23
- `set_min`  in  6  load value, legal 0–59
- `set_sec`  in  6  load value, legal 0–59
- `adj_hour_inc`  in  1  one-cycle pulse: hour +1 mod 24 (honoured only when `run`=0)
- `adj_min_inc`  in  1  one-cycle pulse: minute +1 mod 60, no carry (honoured only when `run`=0)
- `hour_kst`  out  5  current hour 0–23
- `minute`  out  6  current minute 0–59
- `second`  out  6  current second 0–59
- `sec_tick`  out  1  one-cycle pulse, high in the first cycle a new second value is visible
- `day_wrap`  out  1  one-cycle pulse, coincident with `sec_tick` on 23:59:59 → 00:00:00
- `set_err`  out  1  one-cycle pulse: last `set_valid` was rejected

## Operation

- Reset (`rst`=1 at an edge):
  - All outputs go to 0 at that edge (00:00:00, strobes low); prescaler goes to 0.
  - Reset overrides every other input in the same cycle.
  - Reset mid-count discards any partial second.
- Priority per cycle: `rst` > `set_valid` > adjust pulses > prescaler advance.
- Prescaler:
  - When `run`=1: counts 0..`CLK_HZ-1`; at terminal count it returns to 0 and the time advances by one second.
  - When `run`=0: the prescaler holds its value.
- Advance rules:
  - `second`: 59 → 0 with carry to `minute`.
  - `minute`: 59 → 0 with carry to `hour_kst`.
  - `hour_kst`: 23 → 0 and `day_wrap` asserted.
  - No field ever leaves its legal range.
- Load:
  - Accepted only if `set_hour`≤23, `set_min`≤59 and `set_sec`≤59.
  - On accept: all three fields take the set values, the prescaler clears to 0, and `sec_tick`/`day_wrap` stay low that cycle.
  - On reject: time and prescaler are unchanged and `set_err` pulses.
  - Load works in either `run` state.
  - A load on a terminal-count cycle wins; that advance is dropped.
- Adjust:
  - With `run`=0, each pulse increments its field modulo its range with no carry and no strobes.
  - Both pulses in the same cycle apply both increments.
  - With `run`=1, adjust pulses are ignored entirely.
  - Adjust pulses coincident with `set_valid` are ignored.

## Timing

- All outputs are registered; no combinational input-to-output path.
- `set_valid` sampled at edge N → new time (or `set_err`=1) visible after edge N; `set_err` lasts exactly one cycle.
- Advance: if the prescaler equals `CLK_HZ-1` at edge N with `run`=1, the new time, `sec_tick` and (if applicable) `day_wrap` are visible after edge N for exactly one cycle.
- With `run` held at 1, consecutive `sec_tick` pulses are exactly `CLK_HZ` cycles apart. Dropping `run` for K cycles delays the next tick by exactly K cycles.
- After a load with `run`=1, the first `sec_tick` occurs `CLK_HZ` cycles later.
- Adjust pulse at edge N → field updated after edge N.

## Structure

- Shared clock package holds:
  - `HOURS_PER_DAY`=24, `MIN_PER_HOUR`=60, `SEC_PER_MIN`=60
  - the field widths (5/6/6)
  - a `kst_time_t` struct type (hour, minute, second) for reuse by the world-time and display stages
- One sub-module: `tick_prescaler` (params `CLK_HZ`; inputs `clk`, `rst`, `en`, `clr`; output one-cycle `tick`).
- The field counters and the load/adjust logic stay in the top block.

## Test plan

- Reset, then check outputs: `rst` for 2 cycles → 00:00:00, `sec_tick`=`day_wrap`=`set_err`=0. Then `CLK_HZ`=4, `run`=1 → `sec_tick` every 4 cycles, `second` 0→1→2.
- Day wrap: load 23:59:58, `run`=1, `CLK_HZ`=4 → 23:59:59 after 4 cycles; 00:00:00 with `sec_tick`=`day_wrap`=1 after 8 cycles; `day_wrap` low on the next tick.
- Invalid load: from 12:34:56, load 24:00:00, then 10:60:00 → `set_err` pulses each time, time stays 12:34:56, prescaler phase preserved.
- Adjust while stopped: `run`=0 at 23:59:10; `adj_hour_inc` → 00:59:10; `adj_min_inc` → 00:00:10. No `sec_tick`, hour unchanged by the minute wrap.
- Adjust while running: `run`=1 with an adjust pulse → ignored. Load on a terminal-count cycle → loaded value shown, no `sec_tick` that cycle.
- Mid-count reset: `rst` at prescaler=2, time 05:06:07 → 00:00:00 next cycle; first `sec_tick` exactly `CLK_HZ` cycles after `rst` deasserts with `run`=1.

Source files
------------

// File: rtl/kst_clock_counter_pkg.sv
// Shared time-of-day constants and types for the world-clock datapath.
// Also used by the world-time conversion and display stages.
package kst_clock_counter_pkg;

    localparam int HOURS_PER_DAY = 24;
    localparam int MIN_PER_HOUR  = 60;
    localparam int SEC_PER_MIN   = 60;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  minute;
        logic [SEC_W-1:0]  second;
    } kst_time_t;

    function automatic logic time_is_valid(input kst_time_t t);
        return (t.hour   <= HOUR_W'(HOURS_PER_DAY - 1)) &&
               (t.minute <= MIN_W'(MIN_PER_HOUR - 1))   &&
               (t.second <= SEC_W'(SEC_PER_MIN - 1));
    endfunction

endpackage

// File: rtl/kst_clock_counter_tick_prescaler.sv
// Divides the system clock down to one-second advance requests.
// The tick is combinational so the time fields can update on the terminal-count edge itself.
module tick_prescaler #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_HZ);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] count;

    assign tick = en && (count == TERMINAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/kst_clock_counter.sv
// Korea Standard Time keeper: hour/minute/second fields with load, stopped-mode
// adjustment, and per-second / per-day strobes.
module kst_clock_counter
    import kst_clock_counter_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              set_valid,
    input  logic [HOUR_W-1:0] set_hour,
    input  logic [MIN_W-1:0]  set_min,
    input  logic [SEC_W-1:0]  set_sec,
    input  logic              adj_hour_inc,
    input  logic              adj_min_inc,
    output logic [HOUR_W-1:0] hour_kst,
    output logic [MIN_W-1:0]  minute,
    output logic [SEC_W-1:0]  second,
    output logic              sec_tick,
    output logic              day_wrap,
    output logic              set_err
);

    kst_time_t now;
    kst_time_t load_time;
    logic      load_ok;
    logic      tick;
    logic      hour_last, min_last, sec_last;
    logic [HOUR_W-1:0] next_hour;
    logic [MIN_W-1:0]  next_min;
    logic [SEC_W-1:0]  next_sec;

    assign load_time = '{hour: set_hour, minute: set_min, second: set_sec};
    assign load_ok   = time_is_valid(load_time);

    // Any load request, accepted or not, owns the cycle, so the prescaler pauses.
    tick_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (run && !set_valid),
        .clr  (set_valid && load_ok),
        .tick (tick)
    );

    assign hour_last = (now.hour   == HOUR_W'(HOURS_PER_DAY - 1));
    assign min_last  = (now.minute == MIN_W'(MIN_PER_HOUR - 1));
    assign sec_last  = (now.second == SEC_W'(SEC_PER_MIN - 1));

    assign next_hour = hour_last ? '0 : now.hour   + 1'b1;
    assign next_min  = min_last  ? '0 : now.minute + 1'b1;
    assign next_sec  = sec_last  ? '0 : now.second + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            now      <= '0;
            sec_tick <= 1'b0;
            day_wrap <= 1'b0;
            set_err  <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            day_wrap <= 1'b0;
            set_err  <= 1'b0;
            if (set_valid) begin
                if (load_ok) begin
                    now <= load_time;
                end else begin
                    set_err <= 1'b1;
                end
            end else if (!run) begin
                // Manual adjustment never carries between fields.
                if (adj_hour_inc) now.hour   <= next_hour;
                if (adj_min_inc)  now.minute <= next_min;
            end else if (tick) begin
                sec_tick   <= 1'b1;
                now.second <= next_sec;
                if (sec_last) begin
                    now.minute <= next_min;
                    if (min_last) begin
                        now.hour <= next_hour;
                        day_wrap <= hour_last;
                    end
                end
            end
        end
    end

    assign hour_kst = now.hour;
    assign minute   = now.minute;
    assign second   = now.second;

endmodule

// File: tb/tb_kst_clock_counter.sv
// Directed self-checking bench for kst_clock_counter with a 4-cycle second.
// Expected times and strobes are hand-computed for each step.
module tb_kst_clock_counter;

    localparam int CLK_HZ = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic       set_valid = 1'b0;
    logic [4:0] set_hour = '0;
    logic [5:0] set_min = '0;
    logic [5:0] set_sec = '0;
    logic       adj_hour_inc = 1'b0;
    logic       adj_min_inc = 1'b0;
    logic [4:0] hour_kst;
    logic [5:0] minute;
    logic [5:0] second;
    logic       sec_tick;
    logic       day_wrap;
    logic       set_err;

    int vectors = 0;
    int miscompares = 0;

    kst_clock_counter #(
        .CLK_HZ (CLK_HZ)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .set_valid    (set_valid),
        .set_hour     (set_hour),
        .set_min      (set_min),
        .set_sec      (set_sec),
        .adj_hour_inc (adj_hour_inc),
        .adj_min_inc  (adj_min_inc),
        .hour_kst     (hour_kst),
        .minute       (minute),
        .second       (second),
        .sec_tick     (sec_tick),
        .day_wrap     (day_wrap),
        .set_err      (set_err)
    );

    always #5 clk = ~clk;

    // Drives one cycle of inputs, then drops the one-cycle pulses 1 time unit after the edge.
    task automatic applyStimulus(input logic r, input logic rn, input logic sv,
                                 input logic [4:0] sh, input logic [5:0] sm, input logic [5:0] ss,
                                 input logic ah, input logic am);
        rst = r;
        run = rn;
        set_valid = sv;
        set_hour = sh;
        set_min = sm;
        set_sec = ss;
        adj_hour_inc = ah;
        adj_min_inc = am;
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_valid = 1'b0;
        adj_hour_inc = 1'b0;
        adj_min_inc = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [4:0] eh, input logic [5:0] em,
                               input logic [5:0] es, input logic et, input logic ew, input logic ee);
        logic [19:0] observed;
        logic [19:0] expected;
        observed = {hour_kst, minute, second, sec_tick, day_wrap, set_err};
        expected = {eh, em, es, et, ew, ee};
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d:%0d:%0d tick=%b wrap=%b err=%b, expected %0d:%0d:%0d tick=%b wrap=%b err=%b",
                   tag, hour_kst, minute, second, sec_tick, day_wrap, set_err,
                   eh, em, es, et, ew, ee);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset wins over a coincident valid load.
        applyStimulus(1, 0, 1, 5'd1, 6'd2, 6'd3, 0, 0);
        applyStimulus(1, 0, 1, 5'd1, 6'd2, 6'd3, 0, 0);
        checkOutput("reset", 0, 0, 0, 0, 0, 0);

        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        waitCycles(2);
        checkOutput("run_pre_tick", 0, 0, 0, 0, 0, 0);
        waitCycles(1);
        checkOutput("run_tick1", 0, 0, 1, 1, 0, 0);
        waitCycles(1);
        checkOutput("run_tick1_low", 0, 0, 1, 0, 0, 0);
        waitCycles(3);
        checkOutput("run_tick2", 0, 0, 2, 1, 0, 0);

        // Day wrap from 23:59:58.
        applyStimulus(0, 1, 1, 5'd23, 6'd59, 6'd58, 0, 0);
        checkOutput("wrap_load", 23, 59, 58, 0, 0, 0);
        waitCycles(3);
        checkOutput("wrap_pre", 23, 59, 58, 0, 0, 0);
        waitCycles(1);
        checkOutput("wrap_59", 23, 59, 59, 1, 0, 0);
        waitCycles(4);
        checkOutput("wrap_midnight", 0, 0, 0, 1, 1, 0);
        waitCycles(1);
        checkOutput("wrap_low", 0, 0, 0, 0, 0, 0);
        waitCycles(3);
        checkOutput("wrap_next", 0, 0, 1, 1, 0, 0);

        // Invalid loads leave time and prescaler phase alone.
        applyStimulus(0, 0, 1, 5'd12, 6'd34, 6'd56, 0, 0);
        checkOutput("inv_base", 12, 34, 56, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        waitCycles(1);
        checkOutput("inv_phase2", 12, 34, 56, 0, 0, 0);
        applyStimulus(0, 0, 1, 5'd24, 6'd0, 6'd0, 0, 0);
        checkOutput("inv_hour24", 12, 34, 56, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("inv_err_low", 12, 34, 56, 0, 0, 0);
        applyStimulus(0, 0, 1, 5'd10, 6'd60, 6'd0, 1, 0);
        checkOutput("inv_min60", 12, 34, 56, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("inv_resume", 12, 34, 56, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("inv_tick", 12, 34, 57, 1, 0, 0);

        // Adjust while stopped: no carry between fields.
        applyStimulus(0, 0, 1, 5'd23, 6'd59, 6'd10, 0, 0);
        checkOutput("adj_base", 23, 59, 10, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("adj_hour", 0, 59, 10, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("adj_min", 0, 0, 10, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("adj_both", 1, 1, 10, 0, 0, 0);
        applyStimulus(0, 0, 1, 5'd3, 6'd4, 6'd5, 1, 1);
        checkOutput("adj_with_load", 3, 4, 5, 0, 0, 0);

        // Adjust ignored while running; load on terminal count drops the advance.
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 1);
        checkOutput("adj_running", 3, 4, 5, 0, 0, 0);
        waitCycles(2);
        checkOutput("tc_pre", 3, 4, 5, 0, 0, 0);
        applyStimulus(0, 1, 1, 5'd7, 6'd8, 6'd9, 0, 0);
        checkOutput("tc_load", 7, 8, 9, 0, 0, 0);
        waitCycles(3);
        checkOutput("tc_after_pre", 7, 8, 9, 0, 0, 0);
        waitCycles(1);
        checkOutput("tc_after_tick", 7, 8, 10, 1, 0, 0);

        // Reset mid-count discards the partial second.
        applyStimulus(0, 0, 1, 5'd5, 6'd6, 6'd7, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        waitCycles(1);
        checkOutput("mid_base", 5, 6, 7, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("mid_reset", 0, 0, 0, 0, 0, 0);
        waitCycles(3);
        checkOutput("mid_pre", 0, 0, 0, 0, 0, 0);
        waitCycles(1);
        checkOutput("mid_tick", 0, 0, 1, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
